// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC sequencing with branch/trap redirects, stall
// hold with a single pending redirect slot, and a post-redirect flush window.
module fetch_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_target_i,
  output logic        pc_we_o,
  output logic [1:0]  pc_mux_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        upper_only_o,
  output logic [15:0] redirects_o
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [1:0] P8 = 2'd0, BR = 2'd1, TRAP = 2'd2;
  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_e;
  state_e        state_q;
  logic          pend_valid_q, pend_trap_q, upper_q;
  logic [31:0]   pend_tgt_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   redirects_q;
  logic          go, apply, apply_trap;
  logic [31:0]   tgt;
  always_comb begin
    go = state_q != BOOT && !stall_i;
    apply = go && (trap_valid_i || pend_valid_q || br_valid_i);
    apply_trap = trap_valid_i || (pend_valid_q && pend_trap_q);
    // a live trap beats a pending redirect, which beats a live branch
    tgt = trap_valid_i ? trap_target_i : pend_valid_q ? pend_tgt_q : br_target_i;
    pc_we_o = go;
    pc_mux_o = !apply ? P8 : apply_trap ? TRAP : BR;
    redirect_pc_o = apply ? (tgt & 32'hFFFF_FFF8) : '0;
    flush_o = state_q == BOOT || state_q == FLUSH;
    upper_only_o = upper_q;
    redirects_o = redirects_q;
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= BOOT;
      pend_valid_q <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q <= '0;
      upper_q <= 1'b0;
      redirects_q <= '0;
    end else if (stall_i) begin
      if (trap_valid_i || (br_valid_i && !(pend_valid_q && pend_trap_q))) begin
        pend_valid_q <= 1'b1;
        pend_trap_q <= trap_valid_i;
        pend_tgt_q <= trap_valid_i ? trap_target_i : br_target_i;
      end
      state_q <= state_q == FLUSH ? FLUSH : state_q == BOOT ? RUN : HOLD;
    end else if (apply) begin
      pend_valid_q <= 1'b0;
      upper_q <= tgt[2];
      redirects_q <= redirects_q + 16'd1;
      cnt_q <= CW'(FLUSH_CYCLES);
      state_q <= FLUSH;
    end else if (state_q == BOOT) begin
      state_q <= RUN;
    end else begin
      upper_q <= 1'b0;
      if (state_q == FLUSH) cnt_q <= cnt_q - 1'b1;
      state_q <= (state_q == FLUSH && cnt_q != CW'(1)) ? FLUSH : RUN;
    end
  end
endmodule
